// File: rtl/ysyx_220053_lsu.sv
// ysyx_220053_lsu: load/store unit with alignment check, lane shifting, load extension and bus timeout
module ysyx_220053_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mem_op,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [4:0]  rd,
  input  logic        reg_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [1:0]  out_exc
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      state;
  logic [2:0]  op_r, sh_r;
  logic        wen_r;
  logic [31:0] cnt;
  logic        mem, st, mis, sx;
  logic [7:0]  smask;
  logic [63:0] fmask, f, ld_val;
  assign in_ready  = state == IDLE;
  assign dmem_req  = state == REQ;
  assign out_valid = state == RESP;
  always_comb begin
    mem    = mem_ren | mem_wen;
    st     = mem_wen & ~mem_ren;
    mis    = (mem_op[1:0] == 2'b10 & addr[0]) | (mem_op[1:0] == 2'b00 & |addr[1:0]) |
             (mem_op[1:0] == 2'b11 & |addr[2:0]);
    smask  = mem_op[1:0] == 2'b01 ? 8'h01 : mem_op[1:0] == 2'b10 ? 8'h03 :
             mem_op[1:0] == 2'b00 ? 8'h0F : 8'hFF;
    fmask  = mem_op[1:0] == 2'b01 ? 64'hFF : mem_op[1:0] == 2'b10 ? 64'hFFFF :
             mem_op[1:0] == 2'b00 ? 64'hFFFF_FFFF : '1;
    f      = dmem_rdata >> {sh_r, 3'b000};
    sx     = ~op_r[2];
    ld_val = op_r[1:0] == 2'b01 ? {{56{sx & f[7]}}, f[7:0]} :
             op_r[1:0] == 2'b10 ? {{48{sx & f[15]}}, f[15:0]} :
             op_r[1:0] == 2'b00 ? {{32{sx & f[31]}}, f[31:0]} : f;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_r       <= '0;
      sh_r       <= '0;
      wen_r      <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      out_data   <= '0;
      out_rd     <= '0;
      out_wen    <= 1'b0;
      out_exc    <= 2'b00;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r       <= mem_op;
          sh_r       <= addr[2:0];
          wen_r      <= reg_wen;
          out_rd     <= rd;
          cnt        <= '0;
          dmem_addr  <= {addr[63:3], 3'b000};
          dmem_we    <= st;
          dmem_wmask <= st ? smask << addr[2:0] : 8'h00;
          dmem_wdata <= st ? (wdata & fmask) << {addr[2:0], 3'b000} : 64'h0;
          out_data   <= mem ? 64'h0 : addr;
          out_wen    <= mem ? 1'b0 : reg_wen;
          out_exc    <= mem & mis ? 2'b01 : 2'b00;
          state      <= mem & ~mis ? REQ : RESP;
        end
        REQ: if (dmem_ack) begin
          out_data <= dmem_we ? 64'h0 : ld_val;
          out_wen  <= ~dmem_we & wen_r;
          state    <= RESP;
        end else begin
          cnt <= cnt + 32'd1;
          if (TIMEOUT_CYC != 0 && cnt + 32'd1 == TIMEOUT_CYC) begin
            out_exc <= 2'b10;
            state   <= RESP;
          end
        end
        RESP: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// tb_ysyx_220053_lsu: directed scoreboard bench for the load/store unit
module tb_ysyx_220053_lsu;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [2:0]  mem_op = 0;
  logic        mem_ren = 0, mem_wen = 0, reg_wen = 0;
  logic [63:0] addr = 0, wdata = 0;
  logic [4:0]  rd = 0;
  logic        dmem_req, dmem_we, dmem_ack = 0;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [7:0]  dmem_wmask;
  logic        out_valid, out_ready = 0, out_wen;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_exc;
  typedef struct {logic [63:0] data; logic wen; logic [1:0] exc; logic [4:0] rd;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_220053_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mem_op(mem_op),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .addr(addr), .wdata(wdata), .rd(rd),
    .reg_wen(reg_wen), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic ren, input logic wen,
                       input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r,
                       input logic rw);
    in_valid = 1; mem_op = op; mem_ren = ren; mem_wen = wen;
    addr = a; wdata = wd; rd = r; reg_wen = rw;
    @(negedge clk);
    in_valid = 0; mem_ren = 0; mem_wen = 0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
  endtask
  task automatic serve(input int dly, input logic [63:0] rdata);
    repeat (dly) @(negedge clk);
    dmem_ack = 1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack = 0; dmem_rdata = 0;
  endtask
  task automatic drain(output int lat);
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
    if (out_valid && q.size() != 0) begin
      e = q.pop_front();
      chk("out_exc", 64'(out_exc), 64'(e.exc));
      chk("out_wen", 64'(out_wen), 64'(e.wen));
      chk("out_rd", 64'(out_rd), 64'(e.rd));
      if (e.exc == 2'b00) chk("out_data", out_data, e.data);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("back_idle", 64'(in_ready), 64'd1);
  endtask
  task automatic chk_store(input logic [7:0] m, input logic [63:0] d);
    chk("st_req", 64'(dmem_req), 64'd1);
    chk("st_we", 64'(dmem_we), 64'd1);
    chk("st_mask", 64'(dmem_wmask), 64'(m));
    chk("st_wdata", dmem_wdata, d);
  endtask
  initial begin
    int lat, n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_exc", 64'(out_exc), 64'd0);
    chk("rst_mask", 64'(dmem_wmask), 64'd0);
    rst_n = 1;
    @(negedge clk);
    // lb, sign extended
    q.push_back('{64'hFFFF_FFFF_FFFF_FF80, 1'b1, 2'b00, 5'd5});
    issue(3'b001, 1, 0, 64'h8000_0005, 0, 5'd5, 1);
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_addr", dmem_addr, 64'h8000_0000);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_mask", 64'(dmem_wmask), 64'd0);
    serve(0, 64'h0000_80FF_0000_0000);
    drain(lat);
    chk("lb_latency", 64'(lat), 64'd0);
    q.push_back('{64'h80, 1'b1, 2'b00, 5'd6});
    issue(3'b101, 1, 0, 64'h8000_0005, 0, 5'd6, 1);
    serve(2, 64'h0000_80FF_0000_0000);
    drain(lat);
    // lh / lhu / lw / lwu
    q.push_back('{64'hFFFF_FFFF_FFFF_F00D, 1'b1, 2'b00, 5'd9});
    issue(3'b010, 1, 0, 64'h8000_0002, 0, 5'd9, 1);
    serve(1, 64'h0000_0000_F00D_0000);
    drain(lat);
    q.push_back('{64'hF00D, 1'b1, 2'b00, 5'd9});
    issue(3'b110, 1, 0, 64'h8000_0002, 0, 5'd9, 1);
    serve(0, 64'h0000_0000_F00D_0000);
    drain(lat);
    q.push_back('{64'hFFFF_FFFF_8000_0001, 1'b1, 2'b00, 5'd10});
    issue(3'b000, 1, 0, 64'h8000_0004, 0, 5'd10, 1);
    serve(0, 64'h8000_0001_1234_5678);
    drain(lat);
    q.push_back('{64'h8000_0001, 1'b0, 2'b00, 5'd10});
    issue(3'b100, 1, 0, 64'h8000_0004, 0, 5'd10, 0);
    serve(0, 64'h8000_0001_1234_5678);
    drain(lat);
    // stores
    q.push_back('{64'h0, 1'b0, 2'b00, 5'd1});
    issue(3'b010, 0, 1, 64'h8000_0006, 64'h1234, 5'd1, 1);
    chk_store(8'hC0, 64'h1234_0000_0000_0000);
    chk("sh_addr", dmem_addr, 64'h8000_0000);
    serve(1, 0);
    drain(lat);
    q.push_back('{64'h0, 1'b0, 2'b00, 5'd2});
    issue(3'b001, 0, 1, 64'h8000_0003, 64'hABCD, 5'd2, 1);
    chk_store(8'h08, 64'h0000_0000_CD00_0000);
    serve(0, 0);
    drain(lat);
    q.push_back('{64'h0, 1'b0, 2'b00, 5'd3});
    issue(3'b000, 0, 1, 64'h8000_0004, 64'hFFFF_FFFF_1234_5678, 5'd3, 1);
    chk_store(8'hF0, 64'h1234_5678_0000_0000);
    serve(0, 0);
    drain(lat);
    q.push_back('{64'h0, 1'b0, 2'b00, 5'd4});
    issue(3'b011, 0, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd4, 1);
    chk_store(8'hFF, 64'h1122_3344_5566_7788);
    chk("sd_addr", dmem_addr, 64'h8000_0008);
    serve(0, 0);
    drain(lat);
    // ren and wen together behave as a load
    q.push_back('{64'h0123_4567_89AB_CDEF, 1'b1, 2'b00, 5'd8});
    issue(3'b011, 1, 1, 64'h8000_0010, 64'hFFFF, 5'd8, 1);
    chk("rw_we", 64'(dmem_we), 64'd0);
    chk("rw_mask", 64'(dmem_wmask), 64'd0);
    serve(0, 64'h0123_4567_89AB_CDEF);
    drain(lat);
    // misaligned accesses, no bus request
    q.push_back('{64'h0, 1'b0, 2'b01, 5'd11});
    issue(3'b000, 1, 0, 64'h8000_0002, 0, 5'd11, 1);
    chk("mis_req", 64'(dmem_req), 64'd0);
    drain(lat);
    chk("mis_latency", 64'(lat), 64'd0);
    q.push_back('{64'h0, 1'b0, 2'b01, 5'd12});
    issue(3'b010, 0, 1, 64'h8000_0001, 64'h55, 5'd12, 1);
    chk("mis_st_req", 64'(dmem_req), 64'd0);
    drain(lat);
    q.push_back('{64'h0, 1'b0, 2'b01, 5'd13});
    issue(3'b011, 1, 0, 64'h8000_0004, 0, 5'd13, 1);
    drain(lat);
    // non-memory pass-through
    q.push_back('{64'hDEAD_BEEF_0000_1234, 1'b1, 2'b00, 5'd7});
    issue(3'b000, 0, 0, 64'hDEAD_BEEF_0000_1234, 0, 5'd7, 1);
    chk("alu_req", 64'(dmem_req), 64'd0);
    drain(lat);
    chk("alu_latency", 64'(lat), 64'd0);
    // bus timeout after 4 request cycles
    q.push_back('{64'h0, 1'b0, 2'b10, 5'd14});
    issue(3'b011, 1, 0, 64'h8000_0018, 0, 5'd14, 1);
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", 64'(n), 64'd4);
    drain(lat);
    chk("to_latency", 64'(lat), 64'd0);
    // ld with same-cycle ack, write-back stalls 3 cycles
    q.push_back('{64'h8123_4567_89AB_CDEF, 1'b1, 2'b00, 5'd15});
    issue(3'b011, 1, 0, 64'h8000_0008, 0, 5'd15, 1);
    serve(0, 64'h8123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, 64'h8123_4567_89AB_CDEF);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    drain(lat);
    // reset while a request is in flight
    issue(3'b011, 1, 0, 64'h8000_0020, 0, 5'd16, 1);
    chk("mr_req", 64'(dmem_req), 64'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mr_req_drop", 64'(dmem_req), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk("mr_valid", 64'(out_valid), 64'd0);
    dmem_ack = 1; dmem_rdata = 64'hFFFF;
    @(negedge clk);
    dmem_ack = 0;
    @(negedge clk);
    chk("late_ack_ready", 64'(in_ready), 64'd1);
    chk("late_ack_valid", 64'(out_valid), 64'd0);
    chk("late_ack_req", 64'(dmem_req), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end
endmodule

// File: doc/ysyx_220053_lsu.md
Name: ysyx_220053_lsu

Overview:
- Load/store unit sitting directly upstream of the data-memory port. It feeds the memory access interface; results go downstream to write-back.
- Accepts one EX-stage operation per handshake, checks alignment, and issues an 8-byte-aligned request with byte mask and lane-shifted store data.
- Waits for the memory acknowledgement, then extracts and sign- or zero-extends load data.
- Holds the result until write-back accepts it. Only one access is outstanding at a time.

Parameters:
- TIMEOUT_CYC, 255, number of REQ-state cycles without dmem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  EX operation valid
- in_ready  out  1  LSU can accept (high only in IDLE)
- mem_op  in  3  000 lw, 001 lb, 010 lh, 011 ld, 100 lwu, 101 lbu, 110 lhu, 111 reserved
- mem_ren  in  1  load
- mem_wen  in  1  store (width from mem_op[1:0]; mem_op[2] ignored)
- addr  in  64  effective address, or ALU result for non-memory ops
- wdata  in  64  store data, right-aligned
- rd  in  5  destination register
- reg_wen  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  write request
- dmem_addr  out  64  {addr[63:3],3'b000}
- dmem_wdata  out  64  lane-shifted store data
- dmem_wmask  out  8  byte enables
- dmem_ack  in  1  request completed (may assert in the same cycle as dmem_req)
- dmem_rdata  in  64  aligned doubleword, valid with dmem_ack
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts
- out_data  out  64  load result or passed-through addr
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_exc  out  2  00 none, 01 misaligned, 10 bus timeout

Behaviour:
- Reset (rst_n low at a clk edge): state becomes IDLE. All outputs are 0 except in_ready, which is 1. The timeout counter clears. An in-flight request is dropped; a dmem_ack arriving in IDLE is ignored.
- States:
  - IDLE: in_ready=1.
  - REQ: dmem_req=1, address/data/mask/we held stable.
  - RESP: out_valid=1, outputs held stable.
- IDLE transitions on in_valid at a clk edge:
  - mem_ren|mem_wen, aligned → REQ.
  - mem_ren|mem_wen, misaligned → RESP with out_exc=01, out_wen=0, no bus request.
  - neither → RESP with out_data=addr, out_wen=reg_wen, out_exc=00.
- mem_ren and mem_wen both set: treated as a load.
- Size from mem_op[1:0]: 01→1 B, 10→2 B, 00→4 B, 11→8 B. mem_op=111 on a load is treated as ld.
- Alignment: 2 B needs addr[0]=0; 4 B needs addr[1:0]=0; 8 B needs addr[2:0]=0.
- Store lanes, with sh=addr[2:0]:
  - dmem_wmask = size mask (0x01/0x03/0x0F/0xFF) << sh.
  - dmem_wdata = wdata << (8*sh); unused lanes are don't-care but driven 0.
- Loads: dmem_wmask=0, dmem_we=0.
- REQ, dmem_ack=1 → RESP.
  - Load: field = dmem_rdata >> (8*sh), truncated to size.
  - Sign-extend from the field's MSB when mem_op[2]=0; zero-extend when mem_op[2]=1.
  - out_wen=reg_wen.
  - Store: out_data=0, out_wen=0.
- REQ without ack: counter increments. If TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC → RESP with out_exc=10, out_wen=0, dmem_req deasserted.
- RESP, out_ready=1 → IDLE. No same-edge acceptance of a new op (in_ready low in RESP).
- Latency with 0-wait memory: accept edge → REQ (1 cycle) → RESP. out_valid is first high 2 cycles after acceptance. Non-memory/misaligned ops: out_valid 1 cycle after acceptance.
- in_* signals are registered on acceptance and are don't-care afterwards.

Test Plan:
- Reset mid-REQ: assert rst_n=0 for 1 cycle during REQ → next cycle dmem_req=0, in_ready=1, out_valid=0; a late dmem_ack is ignored.
- lb, addr=0x80000005, dmem_rdata=0x0000_80FF_0000_0000 → dmem_addr=0x80000000, out_data=0xFFFF_FFFF_FFFF_FF80. Same access with lbu → out_data=0x80.
- sh, addr=0x80000006, wdata=0x1234 → dmem_wmask=0xC0, dmem_wdata=0x1234_0000_0000_0000, dmem_we=1, out_wen=0.
- lw, addr=0x80000002 → no dmem_req, out_exc=01, out_wen=0, out_valid one cycle after acceptance.
- TIMEOUT_CYC=4, ack never asserted → dmem_req high for exactly 4 cycles, then out_exc=10.
- ld with ack in the same cycle as req, then out_ready held low for 3 cycles → out_valid/out_data stable throughout, in_ready=0; IDLE entered on the edge out_ready=1.
